residual_join: RTL
==================

// Module: residual_join
// PURPOSE
// - Parametrised residual-join stage for ResNet bottleneck blocks.
// - Aligns the main (conv) stream with the shortcut (identity or projection)
//   stream using two elastic FIFOs, adds them in fp32, and applies optional
//   ReLU before or after the add.
// - Counts outputs per frame and flags FIFO overflow or underflow.
// - Replaces the fixed oversized line buffer + add at the end of each
//   layerN_convbM block.
// PARAMETERS
// DATA_WIDTH    32   word width; IEEE-754 single in fp_add_sub
// IMAGE_WIDTH   128  feature-map width
// IMAGE_HEIGHT  128  feature-map height
// CHANNEL_NUM   256  output channels per pixel
// DEPTH         1024 entries per FIFO; power of 2, >=4
// ADD_LAT       2    fp_add_sub pipeline latency; must match the instance
// RELU_POS      2    0=no ReLU, 1=ReLU on main input before add, 2=ReLU after add
// PORTS
// clk            in   1            clock, rising edge
// reset          in   1            async, active-low; 0 = in reset
// valid_main_in  in   1            main-path word strobe
// main_in        in   DATA_WIDTH   main-path word
// valid_skip_in  in   1            shortcut word strobe
// skip_in        in   DATA_WIDTH   shortcut word
// pxl_out        out  DATA_WIDTH   joined word
// valid_out      out  1            pxl_out strobe
// frame_done     out  1            1-cycle pulse together with the last word of a frame
// overflow       out  1            sticky: a push was dropped on a full FIFO
// underflow_err  out  1            sticky: frame_done fired while either FIFO was non-empty
// BEHAVIOUR
// Reset and protocol
// - Reset (reset=0, async):
//   - FIFO pointers and counts = 0; frame counter = 0.
//   - pxl_out=0, valid_out=0, frame_done=0, overflow=0, underflow_err=0.
//   - All pipeline valids are cleared. In-flight words are discarded, not flushed.
// - Valid-only streaming with no backpressure. Each input high at an edge
//   pushes one word into its FIFO.
// - Push to a full FIFO:
//   - The word is dropped and overflow is set.
//   - If a pop happens in the same cycle, the push is accepted instead.
// Issue and arithmetic
// - Issue: at every edge where both FIFOs are non-empty, one word is popped
//   from each and the pair enters the adder. Maximum rate is 1 pair/cycle.
//   Words pushed at edge t can pop at edge t+1 at the earliest (no bypass).
// - RELU_POS=1: if main word bit[31]=1, the main operand is forced to 0
//   before the add.
// - Sum = fp_add_sub(main, skip). Rounding and special values follow
//   fp_add_sub.
// - RELU_POS=2: if sum bit[31]=1, pxl_out = 0 (this also covers -0).
// - Output register: pxl_out and valid_out are registered after the ReLU
//   stage for every RELU_POS.
// - Latency:
//   - Both pushes at edge t into empty FIFOs: valid_out=1 at edge t+ADD_LAT+2.
//   - Steady state: 1 output/cycle.
// Frame accounting
// - FRAME_LEN = IMAGE_WIDTH*IMAGE_HEIGHT*CHANNEL_NUM.
// - The output counter increments on valid_out. frame_done is asserted with
//   output number FRAME_LEN-1, and the counter wraps to 0.
// - underflow_err is set if either FIFO count != 0 at frame_done. This means
//   the streams were misaligned.
// State
// - FSM states: IDLE -> RUN -> IDLE.
//   - IDLE: both FIFOs empty and pipeline empty.
//   - IDLE -> RUN on the first push.
//   - RUN -> IDLE when FIFOs are empty, the pipeline is drained, and
//     frame_done has fired.
// - The FSM state is informational only; issue depends on FIFO occupancy alone.
// - overflow and underflow_err clear only on reset.
// TESTING
// 1. RELU_POS=0. main=0x3F800000 (1.0) and skip=0x40000000 (2.0) at edge 10
//    -> pxl_out=0x40400000 (3.0), valid_out=1 at edge 10+ADD_LAT+2, exactly
//    one cycle wide.
// 2. RELU_POS=2. main=0xC0400000 (-3.0), skip=0x3F800000 (1.0) -> pxl_out=0.
//    Same inputs with RELU_POS=1 -> 0x3F800000.
// 3. 16 skip words, then after 50 idle cycles 16 main words back-to-back
//    -> 16 consecutive outputs in order, each pxl_out = skip[i]+main[i],
//    overflow=0.
// 4. DEPTH=4, push 5 skip words with no main words -> overflow=1 after the
//    5th push. Then push 4 main words -> only 4 outputs (5th skip word dropped).
// 5. IMAGE 2x2, CHANNEL_NUM=2, 8 aligned pairs -> frame_done on the 8th output,
//    underflow_err=0. Add one extra skip word before the 8th output
//    -> underflow_err=1.
// 6. Assert reset for 1 cycle mid-stream at output 3 -> all outputs 0
//    immediately. Then 2 new pairs -> 2 outputs, frame counter restarts at 0.

Source files
------------

// File: rtl/residual_join.sv
// residual_join
//   Joins the main (conv) stream with the shortcut stream of a ResNet
//   bottleneck block. Each stream is buffered in its own elastic FIFO; whenever
//   both FIFOs hold a word, one word is popped from each and the pair is added in
//   fp32. An optional ReLU is applied to the main operand before the add or to
//   the sum after it. Outputs are counted per frame.
//
// Ports
//   clk            in   rising-edge clock
//   reset          in   asynchronous, active-low (0 = in reset)
//   valid_main_in  in   main-path word strobe
//   main_in        in   main-path word (IEEE-754 single)
//   valid_skip_in  in   shortcut word strobe
//   skip_in        in   shortcut word (IEEE-754 single)
//   pxl_out        out  joined word
//   valid_out      out  pxl_out strobe
//   frame_done     out  one-cycle pulse with the last word of a frame
//   overflow       out  sticky: a push was dropped on a full FIFO
//   underflow_err  out  sticky: a FIFO was non-empty when frame_done fired
module residual_join #(
  parameter int DATA_WIDTH   = 32,
  parameter int IMAGE_WIDTH  = 128,
  parameter int IMAGE_HEIGHT = 128,
  parameter int CHANNEL_NUM  = 256,
  parameter int DEPTH        = 1024,
  parameter int ADD_LAT      = 2,
  parameter int RELU_POS     = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_main_in,
  input  logic [DATA_WIDTH-1:0] main_in,
  input  logic                  valid_skip_in,
  input  logic [DATA_WIDTH-1:0] skip_in,
  output logic [DATA_WIDTH-1:0] pxl_out,
  output logic                  valid_out,
  output logic                  frame_done,
  output logic                  overflow,
  output logic                  underflow_err
);
  localparam int AW        = $clog2(DEPTH);
  localparam int FRAME_LEN = IMAGE_WIDTH * IMAGE_HEIGHT * CHANNEL_NUM;
  localparam int FCW       = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [AW:0]    FULL = (AW+1)'(DEPTH);
  localparam logic [FCW-1:0] LAST = FCW'(FRAME_LEN - 1);

  // fp32 add, round-to-nearest-even, subnormals kept, NaN canonicalised.
  // Operands are ordered by magnitude so the result sign is that of x and the
  // mantissa subtraction never goes negative.
  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y, r;
    logic [7:0]  ex, ey, diff;
    logic [4:0]  d;
    logic [9:0]  e;
    logic [26:0] mx, my, msh, mask, m;
    logic [27:0] s;
    logic [24:0] mr;
    logic        rnd;
    r = '0;
    if (a[30:0] >= b[30:0]) begin x = a; y = b; end
    else                    begin x = b; y = a; end
    ex = x[30:23];
    ey = y[30:23];
    if (ex == 8'hFF) begin
      if (x[22:0] != '0 || (ey == 8'hFF && x[31] != y[31])) r = 32'h7FC00000;
      else                                                  r = x;
    end else begin
      // three extra bits: guard, round, sticky
      mx   = {ex != 8'd0, x[22:0], 3'b000};
      my   = {ey != 8'd0, y[22:0], 3'b000};
      diff = ((ex == 8'd0) ? 8'd1 : ex) - ((ey == 8'd0) ? 8'd1 : ey);
      d    = (diff > 8'd27) ? 5'd27 : diff[4:0];
      mask = (27'd1 << d) - 27'd1;
      msh  = (my >> d) | {26'd0, |(my & mask)};
      s    = (x[31] == y[31]) ? ({1'b0, mx} + {1'b0, msh}) : ({1'b0, mx} - {1'b0, msh});
      e    = {2'b00, (ex == 8'd0) ? 8'd1 : ex};
      if (s == '0) begin
        r = {x[31] & y[31], 31'd0};
      end else begin
        if (s[27]) begin
          m = {s[27:2], s[1] | s[0]};
          e = e + 10'd1;
        end else begin
          m = s[26:0];
          // normalise left, stopping at the subnormal exponent
          for (int i = 0; i < 26; i++) begin
            if (!m[26] && e > 10'd1) begin
              m = m << 1;
              e = e - 10'd1;
            end
          end
        end
        rnd = m[2] & (m[1] | m[0] | m[3]);
        mr  = {1'b0, m[26:3]} + {24'd0, rnd};
        if (mr[24]) begin
          mr = mr >> 1;
          e  = e + 10'd1;
        end
        if (e >= 10'd255) r = {x[31], 8'hFF, 23'd0};
        else              r = {x[31], mr[23] ? e[7:0] : 8'd0, mr[22:0]};
      end
    end
    return r;
  endfunction

  // ---------------- FIFOs: index 0 = main, 1 = skip ----------------
  logic                  push_w     [2];
  logic [DATA_WIDTH-1:0] din_w      [2];
  logic [DATA_WIDTH-1:0] rd_data_w  [2];
  logic [AW:0]           fifo_cnt_q [2];
  logic [AW:0]           fifo_cnt_d [2];
  logic                  drop_w     [2];
  logic                  pop_w;

  assign push_w[0] = valid_main_in;
  assign push_w[1] = valid_skip_in;
  assign din_w[0]  = main_in;
  assign din_w[1]  = skip_in;
  // occupancy-only issue; freshly pushed words are not visible until next edge
  assign pop_w = (fifo_cnt_q[0] != '0) && (fifo_cnt_q[1] != '0);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fifo
      logic [DATA_WIDTH-1:0] mem [DEPTH];
      logic [DATA_WIDTH-1:0] rd_q;
      logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
      logic [AW:0]           cnt_q, cnt_d;
      logic                  accept;

      // a pop in the same cycle frees the slot a full FIFO would otherwise refuse
      assign accept = push_w[gi] && ((cnt_q != FULL) || pop_w);

      always_comb begin
        cnt_d = cnt_q;
        if (accept && !pop_w)      cnt_d = cnt_q + (AW+1)'(1);
        else if (!accept && pop_w) cnt_d = cnt_q - (AW+1)'(1);
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          wr_ptr_q <= '0;
          rd_ptr_q <= '0;
          cnt_q    <= '0;
        end else begin
          if (accept) wr_ptr_q <= wr_ptr_q + AW'(1);
          if (pop_w)  rd_ptr_q <= rd_ptr_q + AW'(1);
          cnt_q <= cnt_d;
        end
      end

      always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr_q] <= din_w[gi];
        if (pop_w)  rd_q <= mem[rd_ptr_q];
      end

      assign fifo_cnt_q[gi] = cnt_q;
      assign fifo_cnt_d[gi] = cnt_d;
      assign rd_data_w[gi]  = rd_q;
      assign drop_w[gi]     = push_w[gi] && !accept;
    end
  endgenerate

  // ---------------- adder pipeline ----------------
  logic                  issue_q;
  logic [DATA_WIDTH-1:0] main_op_w, sum_w, relu_w;
  logic                  pipe_v_q [ADD_LAT];
  logic [DATA_WIDTH-1:0] pipe_d_q [ADD_LAT];
  logic                  pipe_busy_w;

  assign main_op_w = (RELU_POS == 1 && rd_data_w[0][DATA_WIDTH-1]) ? '0 : rd_data_w[0];
  assign sum_w     = fp_add(main_op_w, rd_data_w[1]);
  // sign bit test also maps -0 to +0
  assign relu_w    = (RELU_POS == 2 && pipe_d_q[ADD_LAT-1][DATA_WIDTH-1]) ? '0 : pipe_d_q[ADD_LAT-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      issue_q <= 1'b0;
      for (int i = 0; i < ADD_LAT; i++) begin
        pipe_v_q[i] <= 1'b0;
        pipe_d_q[i] <= '0;
      end
    end else begin
      issue_q     <= pop_w;
      pipe_v_q[0] <= issue_q;
      pipe_d_q[0] <= sum_w;
      for (int i = 1; i < ADD_LAT; i++) begin
        pipe_v_q[i] <= pipe_v_q[i-1];
        pipe_d_q[i] <= pipe_d_q[i-1];
      end
    end
  end

  always_comb begin
    pipe_busy_w = issue_q;
    for (int i = 0; i < ADD_LAT; i++) pipe_busy_w = pipe_busy_w | pipe_v_q[i];
  end

  // ---------------- output register and frame accounting ----------------
  logic [DATA_WIDTH-1:0] pxl_out_q;
  logic                  valid_out_q, frame_done_q, overflow_q, underflow_q;
  logic [FCW-1:0]        fcnt_q;
  logic                  frame_end_w;

  assign frame_end_w = pipe_v_q[ADD_LAT-1] && (fcnt_q == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pxl_out_q    <= '0;
      valid_out_q  <= 1'b0;
      frame_done_q <= 1'b0;
      fcnt_q       <= '0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      valid_out_q  <= pipe_v_q[ADD_LAT-1];
      frame_done_q <= frame_end_w;
      if (pipe_v_q[ADD_LAT-1]) begin
        pxl_out_q <= relu_w;
        fcnt_q    <= frame_end_w ? '0 : fcnt_q + FCW'(1);
      end
      overflow_q <= overflow_q | drop_w[0] | drop_w[1];
      // judged on the occupancy seen while frame_done is high
      if (frame_end_w && (fifo_cnt_d[0] != '0 || fifo_cnt_d[1] != '0)) underflow_q <= 1'b1;
    end
  end

  assign pxl_out       = pxl_out_q;
  assign valid_out     = valid_out_q;
  assign frame_done    = frame_done_q;
  assign overflow      = overflow_q;
  assign underflow_err = underflow_q;

  // ---------------- activity FSM (informational) ----------------
  typedef enum logic {IDLE, RUN} state_e;
  state_e state_q, state_d;
  logic   done_seen_q, done_seen_d;

  always_comb begin
    state_d     = state_q;
    done_seen_d = done_seen_q | frame_done_q;
    case (state_q)
      IDLE: begin
        done_seen_d = 1'b0;
        if (valid_main_in || valid_skip_in) state_d = RUN;
      end
      RUN: begin
        if (fifo_cnt_q[0] == '0 && fifo_cnt_q[1] == '0 && !pipe_busy_w &&
            !valid_out_q && done_seen_d) begin
          state_d     = IDLE;
          done_seen_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      done_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      done_seen_q <= done_seen_d;
    end
  end
endmodule
